// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
// Holds the frame FSM state encoding and default sizing constants.
package fifo_uart_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Bundle of the FIFO-side and line-side signals of the UART transmitter.
// The master is the FIFO/host side, the slave is the transmitter.
interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);

    logic                  tx_en;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_rd_en;
    logic                  tx;
    logic                  busy;
    logic [15:0]           frame_cnt;

    modport master (
        output tx_en,
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd_en,
        input  tx,
        input  busy,
        input  frame_cnt
    );

    modport slave (
        input  tx_en,
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd_en,
        output tx,
        output busy,
        output frame_cnt
    );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-time down-counter: load restarts a bit, tick marks its last cycle.
// Parks at zero when no bit is running.
module uart_baud_cnt
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic rd_clk,
    input  logic rst,
    input  logic load,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls characters from a registered-output FIFO.
// One read strobe per frame; data is captured the cycle after the strobe.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic [15:0]           frame_cnt
);

    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_e           state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_q;
    logic [IW-1:0]         bit_q;
    logic                  stop_q;
    logic                  tx_q;
    logic [15:0]           cnt_q;

    logic tick;
    logic load;

    assign fifo_rd_en = (state_q == IDLE) && tx_en && !fifo_empty;
    assign busy       = (state_q != IDLE);
    assign tx         = tx_q;
    assign frame_cnt  = cnt_q;

    // FETCH arms the first bit; every later bit restarts on the tick.
    assign load = (state_q == FETCH) || (busy && tick);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .rd_clk(rd_clk),
        .rst   (rst),
        .load  (load),
        .tick  (tick)
    );

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fifo_rd_en) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    shift_q <= fifo_dout;
                    par_q   <= ^fifo_dout;
                    bit_q   <= '0;
                    stop_q  <= 1'b0;
                    tx_q    <= 1'b0;
                    state_q <= START;
                end
                START: begin
                    if (tick) begin
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_q == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                tx_q    <= par_q;
                                state_q <= PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= STOP;
                            end
                        end else begin
                            bit_q   <= bit_q + IW'(1);
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (stop_q == LAST_STOP) begin
                            cnt_q   <= cnt_q + 16'd1;
                            state_q <= IDLE;
                        end else begin
                            stop_q <= stop_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: 8N1 instance plus an 8E1 instance,
// each fed by a small queue-based FIFO model with registered read data.
module tb_fifo_uart_tx;

    logic clk;
    logic rst;

    int tests;
    int errors;
    int viol_a;
    int viol_b;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    fifo_uart_tx_if #(.DATA_WIDTH(8)) ifa ();
    fifo_uart_tx_if #(.DATA_WIDTH(8)) ifb ();

    fifo_uart_tx #(
        .DATA_WIDTH  (8),
        .CLKS_PER_BIT(4),
        .PARITY_EN   (0),
        .STOP_BITS   (1)
    ) u_dut (
        .rd_clk    (clk),
        .rst       (rst),
        .tx_en     (ifa.tx_en),
        .fifo_empty(ifa.fifo_empty),
        .fifo_dout (ifa.fifo_dout),
        .fifo_rd_en(ifa.fifo_rd_en),
        .tx        (ifa.tx),
        .busy      (ifa.busy),
        .frame_cnt (ifa.frame_cnt)
    );

    fifo_uart_tx #(
        .DATA_WIDTH  (8),
        .CLKS_PER_BIT(4),
        .PARITY_EN   (1),
        .STOP_BITS   (1)
    ) u_dutp (
        .rd_clk    (clk),
        .rst       (rst),
        .tx_en     (ifb.tx_en),
        .fifo_empty(ifb.fifo_empty),
        .fifo_dout (ifb.fifo_dout),
        .fifo_rd_en(ifb.fifo_rd_en),
        .tx        (ifb.tx),
        .busy      (ifb.busy),
        .frame_cnt (ifb.frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO models: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (ifa.fifo_rd_en) begin
            if (q_a.size() == 0) begin
                viol_a++;
            end else begin
                ifa.fifo_dout <= q_a.pop_front();
            end
            ifa.fifo_empty <= (q_a.size() == 0);
        end
        if (ifb.fifo_rd_en) begin
            if (q_b.size() == 0) begin
                viol_b++;
            end else begin
                ifb.fifo_dout <= q_b.pop_front();
            end
            ifb.fifo_empty <= (q_b.size() == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic push_a(input logic [7:0] d);
        q_a.push_back(d);
        ifa.fifo_empty <= 1'b0;
    endtask

    task automatic push_b(input logic [7:0] d);
        q_b.push_back(d);
        ifb.fifo_empty <= 1'b0;
    endtask

    task automatic do_reset();
        ifa.tx_en = 1'b0;
        ifb.tx_en = 1'b0;
        q_a.delete();
        q_b.delete();
        ifa.fifo_empty <= 1'b1;
        ifb.fifo_empty <= 1'b1;
        ifa.fifo_dout  <= 8'h00;
        ifb.fifo_dout  <= 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_rd_a(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (ifa.fifo_rd_en) seen = 1'b1;
        end
    endtask

    task automatic wait_rd_b(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (ifb.fifo_rd_en) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        ifa.tx_en = 1'b0;
        ifb.tx_en = 1'b0;
        ifa.fifo_empty <= 1'b1;
        ifb.fifo_empty <= 1'b1;
        ifa.fifo_dout  <= 8'h00;
        ifb.fifo_dout  <= 8'h00;
        rst = 1'b1;
        #12;
        tests++;
        if (ifa.tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx got %b expected 1", ifa.tx);
        end
        tests++;
        if (ifa.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b expected 0", ifa.busy);
        end
        tests++;
        if (ifa.frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d expected 0", ifa.frame_cnt);
        end
        tests++;
        if (ifa.fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd got %b expected 0", ifa.fifo_rd_en);
        end
        tests++;
        if (ifb.tx !== 1'b1 || ifb.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_par tx=%b busy=%b expected 1/0",
                     ifb.tx, ifb.busy);
        end
        do_reset();
    endtask

    task automatic test_single();
        bit seen;
        int rd;
        int bad;
        logic [9:0] exp;
        exp = {1'b1, 8'hA5, 1'b0};
        do_reset();
        @(posedge clk);
        #1;
        push_a(8'hA5);
        ifa.tx_en = 1'b1;
        wait_rd_a(seen);
        tests++;
        if (!seen) begin
            errors++;
            $display("FAIL single_rd got none expected 1 strobe");
        end
        rd = 1;
        @(negedge clk);
        if (ifa.fifo_rd_en) rd++;
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (ifa.tx !== exp[b]) bad++;
                if (ifa.fifo_rd_en) rd++;
            end
            tests++;
            if (bad != 0) begin
                errors++;
                $display("FAIL single_bit%0d tx=%b expected %b (%0d bad)",
                         b, ifa.tx, exp[b], bad);
            end
        end
        @(negedge clk);
        tests++;
        if (ifa.frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL single_cnt got %0d expected 1", ifa.frame_cnt);
        end
        tests++;
        if (ifa.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy got %b expected 0", ifa.busy);
        end
        tests++;
        if (rd != 1) begin
            errors++;
            $display("FAIL single_rdcnt got %0d expected 1", rd);
        end
    endtask

    task automatic test_back_to_back();
        int edges[$];
        int hi_run;
        int rd;
        int low_run;
        int first_low;
        logic prev;
        do_reset();
        @(posedge clk);
        #1;
        push_a(8'h00);
        push_a(8'hFF);
        push_a(8'h55);
        ifa.tx_en = 1'b1;
        hi_run = 10;
        rd = 0;
        prev = 1'b1;
        low_run = 0;
        first_low = -1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (ifa.fifo_rd_en) rd++;
            if (prev && !ifa.tx && hi_run >= 5) edges.push_back(cyc);
            if (edges.size() == 1 && !ifa.tx) low_run++;
            hi_run = ifa.tx ? hi_run + 1 : 0;
            prev = ifa.tx;
            if (ifa.frame_cnt == 16'd3 && !ifa.busy) break;
        end
        ifa.tx_en = 1'b0;
        tests++;
        if (edges.size() != 3) begin
            errors++;
            $display("FAIL stream_edges got %0d expected 3", edges.size());
        end else begin
            tests++;
            if (edges[1] - edges[0] != 42) begin
                errors++;
                $display("FAIL stream_gap1 got %0d expected 42",
                         edges[1] - edges[0]);
            end
            tests++;
            if (edges[2] - edges[1] != 42) begin
                errors++;
                $display("FAIL stream_gap2 got %0d expected 42",
                         edges[2] - edges[1]);
            end
        end
        tests++;
        if (low_run != 36) begin
            errors++;
            $display("FAIL stream_zero_low got %0d expected 36", low_run);
        end
        tests++;
        if (ifa.frame_cnt !== 16'd3) begin
            errors++;
            $display("FAIL stream_cnt got %0d expected 3", ifa.frame_cnt);
        end
        tests++;
        if (rd != 3) begin
            errors++;
            $display("FAIL stream_rdcnt got %0d expected 3", rd);
        end
    endtask

    task automatic test_parity();
        bit seen;
        int bad;
        logic [10:0] exp;
        exp = {1'b1, 1'b1, 8'h07, 1'b0};
        do_reset();
        @(posedge clk);
        #1;
        push_b(8'h07);
        ifb.tx_en = 1'b1;
        wait_rd_b(seen);
        tests++;
        if (!seen) begin
            errors++;
            $display("FAIL parity_rd got none expected 1 strobe");
        end
        @(negedge clk);
        for (int b = 0; b < 11; b++) begin
            bad = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (ifb.tx !== exp[b]) bad++;
            end
            tests++;
            if (bad != 0) begin
                errors++;
                $display("FAIL parity_bit%0d tx=%b expected %b (%0d bad)",
                         b, ifb.tx, exp[b], bad);
            end
        end
        tests++;
        if (ifb.busy !== 1'b1) begin
            errors++;
            $display("FAIL parity_len_last got busy=%b expected 1", ifb.busy);
        end
        @(negedge clk);
        tests++;
        if (ifb.busy !== 1'b0) begin
            errors++;
            $display("FAIL parity_len_end got busy=%b expected 0", ifb.busy);
        end
        tests++;
        if (ifb.frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL parity_cnt got %0d expected 1", ifb.frame_cnt);
        end
        ifb.tx_en = 1'b0;
    endtask

    task automatic test_empty();
        int rd;
        int txlo;
        int bsy;
        do_reset();
        ifa.tx_en = 1'b1;
        rd = 0;
        txlo = 0;
        bsy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ifa.fifo_rd_en !== 1'b0) rd++;
            if (ifa.tx !== 1'b1) txlo++;
            if (ifa.busy !== 1'b0) bsy++;
        end
        tests++;
        if (rd != 0) begin
            errors++;
            $display("FAIL empty_rd got %0d strobes expected 0", rd);
        end
        tests++;
        if (txlo != 0) begin
            errors++;
            $display("FAIL empty_tx got %0d low cycles expected 0", txlo);
        end
        tests++;
        if (bsy != 0) begin
            errors++;
            $display("FAIL empty_busy got %0d busy cycles expected 0", bsy);
        end
        ifa.tx_en = 1'b0;
    endtask

    task automatic test_tx_en_drop();
        bit seen;
        int bad;
        int rd;
        logic [9:0] exp;
        exp = {1'b1, 8'h3C, 1'b0};
        do_reset();
        @(posedge clk);
        #1;
        push_a(8'h3C);
        push_a(8'h11);
        ifa.tx_en = 1'b1;
        wait_rd_a(seen);
        tests++;
        if (!seen) begin
            errors++;
            $display("FAIL drop_rd got none expected 1 strobe");
        end
        @(negedge clk);
        bad = 0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (ifa.tx !== exp[b]) bad++;
                if (b == 3 && c == 1) ifa.tx_en = 1'b0;
            end
        end
        tests++;
        if (bad != 0) begin
            errors++;
            $display("FAIL drop_frame got %0d bad cycles expected 0", bad);
        end
        rd = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ifa.fifo_rd_en) rd++;
        end
        tests++;
        if (rd != 0) begin
            errors++;
            $display("FAIL drop_hold_rd got %0d expected 0", rd);
        end
        tests++;
        if (ifa.frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL drop_cnt got %0d expected 1", ifa.frame_cnt);
        end
        tests++;
        if (ifa.busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_busy got %b expected 0", ifa.busy);
        end
        tests++;
        if (q_a.size() != 1) begin
            errors++;
            $display("FAIL drop_fifo_level got %0d expected 1", q_a.size());
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int bad;
        logic [9:0] exp;
        exp = {1'b1, 8'h00, 1'b0};
        @(posedge clk);
        #1;
        push_a(8'h00);
        ifa.tx_en = 1'b1;
        wait_rd_a(seen);
        tests++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_rd got none expected 1 strobe");
        end
        repeat (19) @(negedge clk);
        tests++;
        if (ifa.tx !== 1'b0 || ifa.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre tx=%b busy=%b expected 0/1",
                     ifa.tx, ifa.busy);
        end
        #1 rst = 1'b1;
        #1;
        tests++;
        if (ifa.tx !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst_tx got %b expected 1", ifa.tx);
        end
        tests++;
        if (ifa.frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_rst_cnt got %0d expected 0", ifa.frame_cnt);
        end
        tests++;
        if (ifa.busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_busy got %b expected 0", ifa.busy);
        end
        #1 rst = 1'b0;
        #1;
        tests++;
        if (ifa.fifo_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_post_rd got %b expected 1", ifa.fifo_rd_en);
        end
        @(negedge clk);
        bad = 0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (ifa.tx !== exp[b]) bad++;
            end
        end
        tests++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mid_next_frame got %0d bad cycles expected 0", bad);
        end
        @(negedge clk);
        tests++;
        if (ifa.frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL mid_next_cnt got %0d expected 1", ifa.frame_cnt);
        end
        tests++;
        if (viol_a != 0 || viol_b != 0) begin
            errors++;
            $display("FAIL underflow got %0d/%0d expected 0/0",
                     viol_a, viol_b);
        end
        ifa.tx_en = 1'b0;
    endtask

    initial begin
        tests = 0;
        errors = 0;
        viol_a = 0;
        viol_b = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_empty();
        test_tx_en_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
